button_monitor: RTL and testbench
=================================

// Module: button_monitor
// PURPOSE
//  Conditions one raw push-button input for the digital-lock datapath.
//  Synchronises the asynchronous input, debounces it, and emits a single-cycle
//  pulse on each debounced press (0->1 of the cleaned level).
//  Sits between a board key pin and the lock FSM, one instance per button.
// PARAMETERS
//  SYNC_STAGES      2        synchroniser flops on buttonPress; legal >=2
//  DEBOUNCE_CYCLES  500000   consecutive cycles a new level must hold before it is
//                            accepted (10 ms @ 50 MHz); legal >=1
// PORTS
//  clock        in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high; clears all state
//  buttonPress  in   1  raw button level, asynchronous, active-high (1 = pressed)
//  buttonEdge   out  1  registered one-cycle pulse per debounced press
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. While reset=1 at an edge,
//    all flops clear: sync chain=0, stable level=0 (released), counter=0,
//    buttonEdge=0.
//  - Synchroniser: SYNC_STAGES-deep shift register. sync_out = buttonPress
//    delayed SYNC_STAGES edges.
//  - Debounce: a stable level register plus a counter of width
//    $clog2(DEBOUNCE_CYCLES+1).
//    - sync_out==stable: counter <= 0.
//    - sync_out!=stable and counter<DEBOUNCE_CYCLES-1: counter <= counter+1.
//    - sync_out!=stable and counter==DEBOUNCE_CYCLES-1: stable <= sync_out,
//      counter <= 0.
//    - Any glitch shorter than DEBOUNCE_CYCLES cycles (after sync) restarts the
//      count; stable does not change.
//  - Edge output:
//    - buttonEdge <= 1 on exactly the edge where stable goes 0->1; otherwise 0.
//    - Never high two consecutive cycles.
//    - Release (1->0) is debounced identically and produces no pulse.
//  - Latency: input high and steady from edge k (k = first sampling edge, counted
//    as 1). buttonEdge is high for the one cycle after edge
//    k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
//  - Holding the button indefinitely gives exactly one pulse. A new pulse needs a
//    debounced release followed by a debounced press.
//  - Reset mid-debounce discards the partial count; no pulse.
//  - Button held across reset deassertion is treated as a fresh press: one pulse
//    after full latency.
//  - No combinational path from buttonPress to buttonEdge.
// STRUCTURE
//  - No shared package required; parameters are module-local.
//  - One sub-module is natural: button_debouncer (synchroniser + counter ->
//    clean level).
//  - button_monitor adds the stable-delay flop and rising-edge pulse.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//  1. reset=1 for 3 cycles, button=0
//     -> buttonEdge=0 throughout and after release of reset.
//  2. Clean press: button 0->1 sampled at edge k, held 20 cycles
//     -> buttonEdge=1 only for the cycle after edge k+5, 0 elsewhere.
//  3. Bounce: button toggles 1,0,1,0 on successive cycles, then steady 1
//     -> exactly one pulse, 6 edges after steady 1 begins.
//  4. Release and re-press: hold 1 (pulse), drop to 0 for 10 cycles, back to 1
//     -> second single pulse. A 0-glitch of 3 cycles while held
//     -> no extra pulse.
//  5. Reset asserted 2 edges into a press
//     -> no pulse.
//     Button kept high through reset deassertion
//     -> one pulse 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/button_monitor_pkg.sv
// Shared types and helpers for the push-button conditioning path.
// Debounced level encoding and counter sizing.
package button_monitor_pkg;

  typedef enum logic {
    LVL_RELEASED = 1'b0,
    LVL_PRESSED  = 1'b1
  } level_e;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_monitor_debouncer.sv
// Synchroniser plus hold-time debouncer producing a clean level.
// Also exposes the level about to be committed at the next edge.
module button_monitor_debouncer
  import button_monitor_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   raw,
  output level_e level,
  output level_e level_next
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          count;
  level_e                 sync_out;

  assign sync_out = level_e'(sync_q[SYNC_STAGES-1]);

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // A differing level is accepted only on its final qualifying cycle.
  always_comb begin
    level_next = level;
    if (sync_out != level && count == LAST) begin
      level_next = sync_out;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      level <= LVL_RELEASED;
      count <= '0;
    end else if (sync_out == level) begin
      count <= '0;
    end else if (count == LAST) begin
      level <= level_next;
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/button_monitor.sv
// Conditions one raw key input into a single pulse per press.
// Pulse is registered together with the debounced level update.
module button_monitor
  import button_monitor_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic buttonPress,
  output logic buttonEdge
);

  level_e level;
  level_e level_next;

  button_monitor_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock     (clock),
    .reset     (reset),
    .raw       (buttonPress),
    .level     (level),
    .level_next(level_next)
  );

  // Fire on the edge where the clean level moves released -> pressed.
  always_ff @(posedge clock) begin
    if (reset) begin
      buttonEdge <= 1'b0;
    end else begin
      buttonEdge <= (level == LVL_RELEASED) &&
                    (level_next == LVL_PRESSED);
    end
  end

endmodule

// File: tb/tb_button_monitor.sv
// Bench for button_monitor: directed scenarios plus random traffic,
// checked each cycle against a sliding-window model.
module tb_button_monitor;

  localparam int S = 2;
  localparam int D = 4;

  logic clock;
  logic reset;
  logic buttonPress;
  logic buttonEdge;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = -1;
  int start;
  bit cur;

  // model state
  int pipe[$];
  int win[$];
  int m_stable;
  bit exp_edge;

  button_monitor #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .buttonPress(buttonPress),
    .buttonEdge (buttonEdge)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Level seen by the debouncer is the pin value S edges ago.
  // The clean level flips once the last D seen values all oppose it.
  task automatic model(input bit b, input bit r);
    int u;
    bit flip;
    if (r) begin
      pipe.delete();
      for (int i = 0; i < S; i++) pipe.push_back(0);
      win.delete();
      m_stable = 0;
      exp_edge = 1'b0;
    end else begin
      u = pipe.pop_front();
      pipe.push_back(int'(b));
      win.push_back(u);
      if (win.size() > D) void'(win.pop_front());
      flip = (win.size() == D);
      foreach (win[i]) if (win[i] == m_stable) flip = 1'b0;
      exp_edge = flip && (m_stable == 0);
      if (flip) m_stable = 1 - m_stable;
    end
  endtask

  task automatic step(input bit b, input bit r, input string tag);
    @(negedge clock);
    buttonPress = b;
    reset = r;
    @(posedge clock);
    #1;
    cyc++;
    model(b, r);
    checks++;
    assert (buttonEdge === exp_edge) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b",
             tag, cyc, buttonEdge, exp_edge);
    end
    if (buttonEdge === 1'b1) begin
      pulses++;
      pulse_cyc = cyc;
    end
  endtask

  task automatic chk(input int obs, input int expv, input string tag);
    checks++;
    assert (obs == expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b1;
    buttonPress = 1'b0;

    // reset with button released
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "reset");
    pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle");
    chk(pulses, 0, "idle_pulses");

    // clean press
    pulses = 0;
    start = cyc + 1;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "press");
    chk(pulses, 1, "press_pulses");
    chk(pulse_cyc, start + 5, "press_latency");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "release");

    // bounce then steady
    pulses = 0;
    step(1'b1, 1'b0, "bounce");
    step(1'b0, 1'b0, "bounce");
    step(1'b1, 1'b0, "bounce");
    step(1'b0, 1'b0, "bounce");
    start = cyc + 1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "bounce_hold");
    chk(pulses, 1, "bounce_pulses");
    chk(pulse_cyc, start + 5, "bounce_latency");

    // release and re-press
    pulses = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "drop");
    start = cyc + 1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "repress");
    chk(pulses, 1, "repress_pulses");
    chk(pulse_cyc, start + 5, "repress_latency");

    // short low glitch while held
    pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "glitch");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "glitch_hold");
    chk(pulses, 0, "glitch_pulses");

    // reset mid-press, button held across reset release
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "release2");
    pulses = 0;
    step(1'b1, 1'b0, "pre_reset");
    step(1'b1, 1'b0, "pre_reset");
    step(1'b1, 1'b1, "mid_reset");
    step(1'b1, 1'b1, "mid_reset");
    chk(pulses, 0, "reset_pulses");
    start = cyc + 1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "post_reset");
    chk(pulses, 1, "post_reset_pulses");
    chk(pulse_cyc, start + 5, "post_reset_latency");

    // random bursty traffic with occasional reset
    cur = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) cur = ~cur;
      step(cur, ($urandom_range(0, 99) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
